// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V widths, memory op encoding and op helpers
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MEM_LB,
        MEM_LH,
        MEM_LW,
        MEM_LBU,
        MEM_LHU,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } mem_op_e;

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Byte accesses can never straddle a lane boundary.
    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return lo[0];
            MEM_LW, MEM_SW:          return lo != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data memory request/response bus between LSU and memory
// master: req/we/be/addr/wdata out, gnt/rvalid/rdata in. slave: the reverse.
interface lsu_if;
    import riscv_pkg::*;

    logic            req;
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane mask, store replication and load extraction
// op_i/lo_i select the access; wdata_i -> wdata_o (lane replicated);
// rdata_i -> rdata_o (shifted down and sign/zero extended); be_o is the lane mask.
module lsu_align
    import riscv_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {lo_i, 3'b000};
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;
        case (op_i)
            MEM_LB, MEM_LBU, MEM_SB: be_o = 4'b0001 << lo_i;
            MEM_LH, MEM_LHU, MEM_SH: be_o = 4'b0011 << lo_i;
            default:                 be_o = 4'b1111;
        endcase
        case (op_i)
            MEM_SB:  wdata_o = {4{wdata_i[7:0]}};
            MEM_SH:  wdata_o = {2{wdata_i[15:0]}};
            default: wdata_o = wdata_i;
        endcase
        case (op_i)
            MEM_LB:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LBU: rdata_o = {24'h0, shifted[7:0]};
            MEM_LH:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            MEM_LHU: rdata_o = {16'h0, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one outstanding memory op, registered bus and writeback
// ex_valid/ex_ready/mem_op/addr/wdata/rd_in: op from EX; dmem: memory bus (master);
// wb_valid/wb_rdata/wb_rd/wb_err: one-cycle completion pulse.
module lsu
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  mem_op_e         mem_op,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      rd_in,
    lsu_if.master           dmem,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_rdata,
    output logic [4:0]      wb_rd,
    output logic            wb_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e          state_q, state_d;
    mem_op_e         op_q, op_d;
    logic [1:0]      lo_q, lo_d;
    logic [4:0]      rd_q, rd_d;
    logic            req_q, req_d, we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic            wb_valid_q, wb_valid_d, wb_err_q, wb_err_d;
    logic [XLEN-1:0] wb_rdata_q, wb_rdata_d;
    logic [4:0]      wb_rd_q, wb_rd_d;

    mem_op_e         al_op;
    logic [1:0]      al_lo;
    logic [3:0]      al_be;
    logic [XLEN-1:0] al_wdata, al_rdata;

    // One aligner serves both directions: in IDLE it shapes the incoming op,
    // afterwards it sees the latched op so WAIT can extract the read data.
    assign al_op = (state_q == S_IDLE) ? mem_op    : op_q;
    assign al_lo = (state_q == S_IDLE) ? addr[1:0] : lo_q;

    lsu_align u_align (
        .op_i    (al_op),
        .lo_i    (al_lo),
        .wdata_i (wdata),
        .rdata_i (dmem.rdata),
        .be_o    (al_be),
        .wdata_o (al_wdata),
        .rdata_o (al_rdata)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lo_d       = lo_q;
        rd_d       = rd_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wb_valid_d = 1'b0;
        wb_err_d   = wb_err_q;
        wb_rdata_d = wb_rdata_q;
        wb_rd_d    = wb_rd_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (is_misaligned(mem_op, addr[1:0])) begin
                        wb_valid_d = 1'b1;
                        wb_err_d   = 1'b1;
                        wb_rdata_d = '0;
                        wb_rd_d    = rd_in;
                    end else begin
                        op_d    = mem_op;
                        lo_d    = addr[1:0];
                        rd_d    = rd_in;
                        req_d   = 1'b1;
                        we_d    = is_store(mem_op);
                        be_d    = al_be;
                        addr_d  = {addr[XLEN-1:2], 2'b00};
                        wdata_d = al_wdata;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem.gnt) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    if (is_store(op_q)) begin
                        wb_valid_d = 1'b1;
                        wb_err_d   = 1'b0;
                        wb_rdata_d = '0;
                        wb_rd_d    = '0;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem.rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b0;
                    wb_rdata_d = al_rdata;
                    wb_rd_d    = rd_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= MEM_LB;
            lo_q       <= '0;
            rd_q       <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_err_q   <= 1'b0;
            wb_rdata_q <= '0;
            wb_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lo_q       <= lo_d;
            rd_q       <= rd_d;
            req_q      <= req_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_err_q   <= wb_err_d;
            wb_rdata_q <= wb_rdata_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    assign ex_ready   = (state_q == S_IDLE);
    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.be    = be_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_err     = wb_err_q;
    assign wb_rdata   = wb_rdata_q;
    assign wb_rd      = wb_rd_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized self-checking bench for lsu against a behavioural model
module tb_lsu;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    mem_op_e     mem_op = MEM_LB;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  rd_in = '0;
    logic        wb_valid;
    logic [31:0] wb_rdata;
    logic [4:0]  wb_rd;
    logic        wb_err;
    int          total = 0;
    int          bad = 0;

    lsu_if dmem ();

    lsu dut (
        .clk      (clk),
        .rst      (rst),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .mem_op   (mem_op),
        .addr     (addr),
        .wdata    (wdata),
        .rd_in    (rd_in),
        .dmem     (dmem),
        .wb_valid (wb_valid),
        .wb_rdata (wb_rdata),
        .wb_rd    (wb_rd),
        .wb_err   (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural model: access size in bytes and derived expectations.
    function automatic int m_size(input mem_op_e op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            default:                 return 4;
        endcase
    endfunction

    function automatic bit m_store(input mem_op_e op);
        return op == MEM_SB || op == MEM_SH || op == MEM_SW;
    endfunction

    function automatic bit m_misaligned(input mem_op_e op, input logic [31:0] a);
        return (a % m_size(op)) != 0;
    endfunction

    function automatic logic [31:0] m_be(input mem_op_e op, input logic [31:0] a);
        int s = m_size(op);
        if (s == 4) return 32'd15;
        return ((1 << s) - 1) << (a % 4);
    endfunction

    function automatic logic [31:0] m_wdata(input mem_op_e op, input logic [31:0] w);
        case (m_size(op))
            1:       return (w & 32'hFF) * 32'h01010101;
            2:       return (w & 32'hFFFF) * 32'h00010001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input mem_op_e op, input logic [31:0] a,
                                           input logic [31:0] r);
        longint v;
        int     bits = 8 * m_size(op);
        v = longint'(r >> (8 * (a % 4)));
        if (bits < 32) begin
            v = v % (64'sd1 <<< bits);
            if ((op == MEM_LB || op == MEM_LH) && v >= (64'sd1 <<< (bits - 1)))
                v = v - (64'sd1 <<< bits);
        end
        return 32'(v);
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete operation: issue, serve the bus with the given delays, check writeback.
    task automatic run_op(input mem_op_e op, input logic [31:0] a, input logic [31:0] w,
                          input logic [4:0] rd, input int gd, input int rvd,
                          input logic [31:0] rdat, input string tag);
        check({tag, ".ready"}, 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; mem_op = op; addr = a; wdata = w; rd_in = rd;
        tick();
        ex_valid = 1'b0;
        if (m_misaligned(op, a)) begin
            check({tag, ".mis_valid"}, 32'(wb_valid), 32'd1);
            check({tag, ".mis_err"},   32'(wb_err),   32'd1);
            check({tag, ".mis_rdata"}, wb_rdata,      32'd0);
            check({tag, ".mis_rd"},    32'(wb_rd),    32'(rd));
            check({tag, ".mis_req"},   32'(dmem.req), 32'd0);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                check({tag, ".req"},   32'(dmem.req),  32'd1);
                check({tag, ".we"},    32'(dmem.we),   32'(m_store(op)));
                check({tag, ".be"},    32'(dmem.be),   m_be(op, a));
                check({tag, ".addr"},  dmem.addr,      a - (a % 4));
                if (m_store(op)) check({tag, ".wdata"}, dmem.wdata, m_wdata(op, w));
                check({tag, ".busy"},  32'(ex_ready),  32'd0);
                if (i == gd) dmem.gnt = 1'b1;
                tick();
            end
            dmem.gnt = 1'b0;
            check({tag, ".req_off"}, 32'(dmem.req), 32'd0);
            if (m_store(op)) begin
                check({tag, ".st_valid"}, 32'(wb_valid), 32'd1);
                check({tag, ".st_err"},   32'(wb_err),   32'd0);
                check({tag, ".st_rd"},    32'(wb_rd),    32'd0);
                check({tag, ".st_rdata"}, wb_rdata,      32'd0);
            end else begin
                for (int i = 0; i <= rvd; i++) begin
                    check({tag, ".ld_wait"}, 32'(wb_valid), 32'd0);
                    if (i == rvd) begin
                        dmem.rvalid = 1'b1;
                        dmem.rdata  = rdat;
                    end
                    tick();
                end
                dmem.rvalid = 1'b0;
                dmem.rdata  = $urandom;
                check({tag, ".ld_valid"}, 32'(wb_valid), 32'd1);
                check({tag, ".ld_err"},   32'(wb_err),   32'd0);
                check({tag, ".ld_rd"},    32'(wb_rd),    32'(rd));
                check({tag, ".ld_rdata"}, wb_rdata,      m_load(op, a, rdat));
            end
        end
        tick();
        check({tag, ".pulse"}, 32'(wb_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req"},   32'(dmem.req), 32'd0);
        check({tag, ".we"},    32'(dmem.we),  32'd0);
        check({tag, ".be"},    32'(dmem.be),  32'd0);
        check({tag, ".valid"}, 32'(wb_valid), 32'd0);
        check({tag, ".err"},   32'(wb_err),   32'd0);
        check({tag, ".rdata"}, wb_rdata,      32'd0);
        check({tag, ".rd"},    32'(wb_rd),    32'd0);
        check({tag, ".ready"}, 32'(ex_ready), 32'd1);
    endtask

    initial begin
        dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        run_op(MEM_SW,  32'h100, 32'hDEADBEEF, 5'd3, 2, 0, 32'h0, "sw");
        run_op(MEM_LB,  32'h103, 32'h0, 5'd7, 0, 1, 32'h80FF1234, "lb");
        run_op(MEM_LBU, 32'h103, 32'h0, 5'd8, 1, 0, 32'h80FF1234, "lbu");
        run_op(MEM_LH,  32'h102, 32'h0, 5'd9, 0, 0, 32'h8001ABCD, "lh");
        run_op(MEM_LHU, 32'h102, 32'h0, 5'd10, 0, 2, 32'h8001ABCD, "lhu");
        run_op(MEM_SH,  32'h102, 32'h00001234, 5'd11, 0, 0, 32'h0, "sh");
        run_op(MEM_LW,  32'h101, 32'h0, 5'd12, 0, 0, 32'h0, "lw_mis");
        run_op(MEM_SH,  32'h103, 32'h5555, 5'd13, 0, 0, 32'h0, "sh_mis");

        // Reset while waiting for read data abandons the load.
        ex_valid = 1'b1; mem_op = MEM_LW; addr = 32'h200; rd_in = 5'd4;
        tick();
        ex_valid = 1'b0; dmem.gnt = 1'b1;
        tick();
        dmem.gnt = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 32'hCAFEF00D;
        tick();
        dmem.rvalid = 1'b0;
        check_reset_outputs("rst_wait");
        tick();
        check_reset_outputs("rst_wait2");

        // Back-to-back with ex_valid held: SB then LW.
        ex_valid = 1'b1; mem_op = MEM_SB; addr = 32'h201; wdata = 32'h000000A5; rd_in = 5'd1;
        tick();
        check("b2b.sb_be", 32'(dmem.be), 32'h2);
        check("b2b.sb_wd", dmem.wdata, 32'hA5A5A5A5);
        dmem.gnt = 1'b1;
        mem_op = MEM_LW; addr = 32'h204; rd_in = 5'd2;
        tick();
        dmem.gnt = 1'b0;
        check("b2b.sb_valid", 32'(wb_valid), 32'd1);
        check("b2b.ready",    32'(ex_ready), 32'd1);
        tick();
        ex_valid = 1'b0;
        check("b2b.pulse",   32'(wb_valid),  32'd0);
        check("b2b.lw_req",  32'(dmem.req),  32'd1);
        check("b2b.lw_we",   32'(dmem.we),   32'd0);
        check("b2b.lw_be",   32'(dmem.be),   32'hF);
        check("b2b.lw_addr", dmem.addr,      32'h204);
        dmem.gnt = 1'b1;
        tick();
        dmem.gnt = 1'b0; dmem.rvalid = 1'b1; dmem.rdata = 32'h13579BDF;
        tick();
        dmem.rvalid = 1'b0;
        check("b2b.lw_valid", 32'(wb_valid), 32'd1);
        check("b2b.lw_rd",    32'(wb_rd),    32'd2);
        check("b2b.lw_rdata", wb_rdata,      32'h13579BDF);
        tick();

        for (int n = 0; n < 150; n++) begin
            mem_op_e op = mem_op_e'(3'($urandom_range(0, 7)));
            run_op(op, 32'h1000 + 32'($urandom_range(0, 1023)), $urandom,
                   5'($urandom_range(0, 31)), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
